// File: rtl/acl_cmd_arbiter_if.sv
// Requester/driver handshake bundle for acl_cmd_arbiter.
// master = requesters + ADXL362 driver side, slave = the arbiter.
interface acl_cmd_arbiter_if;
  logic       i_acl_command_ready;
  logic       i_req_a_valid;
  logic       i_req_b_valid;
  logic [2:0] i_req_a_cmd;
  logic [2:0] i_req_b_cmd;
  logic       o_req_a_done;
  logic       o_req_b_done;
  logic       o_req_a_err;
  logic       o_req_b_err;
  logic       o_acl_cmd_init_measur_mode;
  logic       o_acl_cmd_start_measur_mode;
  logic       o_acl_cmd_init_linked_mode;
  logic       o_acl_cmd_start_linked_mode;
  logic       o_acl_cmd_soft_reset;
  logic       o_grant_b;
  logic       o_busy;
  logic       o_timeout_err;

  modport master (
    output i_acl_command_ready, i_req_a_valid, i_req_b_valid, i_req_a_cmd, i_req_b_cmd,
    input  o_req_a_done, o_req_b_done, o_req_a_err, o_req_b_err,
           o_acl_cmd_init_measur_mode, o_acl_cmd_start_measur_mode,
           o_acl_cmd_init_linked_mode, o_acl_cmd_start_linked_mode,
           o_acl_cmd_soft_reset, o_grant_b, o_busy, o_timeout_err
  );

  modport slave (
    input  i_acl_command_ready, i_req_a_valid, i_req_b_valid, i_req_a_cmd, i_req_b_cmd,
    output o_req_a_done, o_req_b_done, o_req_a_err, o_req_b_err,
           o_acl_cmd_init_measur_mode, o_acl_cmd_start_measur_mode,
           o_acl_cmd_init_linked_mode, o_acl_cmd_start_linked_mode,
           o_acl_cmd_soft_reset, o_grant_b, o_busy, o_timeout_err
  );
endinterface

// File: rtl/acl_cmd_arbiter.sv
// Two-requester arbiter for the ADXL362 driver command port (A = tester, B = console).
// Optional ISSUE/BUSY watchdog enabled by defining ACL_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for driver ready and a valid request
// ISSUE | strobe for latched cmd high until driver drops ready
// BUSY  | driver executing, waiting for ready to return
// DONE  | one-cycle done/err pulse to the owner
module acl_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned CNT_W          = 15
) (
  input logic               i_clk_20mhz,
  input logic               i_rstn_20mhz,
  acl_cmd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [2:0] cmd_q, cmd_d;
  logic       rr_q, rr_d;
  logic       err_q, err_d;

  logic       sr_a, sr_b;
  logic       pick_b;
  logic [2:0] pick_cmd;
  logic       pick_legal;
  logic       timeout_hit;

  assign sr_a = bus.i_req_a_valid && (bus.i_req_a_cmd == 3'd5);
  assign sr_b = bus.i_req_b_valid && (bus.i_req_b_cmd == 3'd5);

  // Soft reset outranks the round-robin; rr_q names the preferred side on any tie.
  always_comb begin
    pick_b = 1'b0;
    if (sr_a && sr_b)
      pick_b = rr_q;
    else if (sr_a)
      pick_b = 1'b0;
    else if (sr_b)
      pick_b = 1'b1;
    else if (bus.i_req_a_valid && bus.i_req_b_valid)
      pick_b = rr_q;
    else
      pick_b = bus.i_req_b_valid;
  end

  assign pick_cmd   = pick_b ? bus.i_req_b_cmd : bus.i_req_a_cmd;
  assign pick_legal = (pick_cmd >= 3'd1) && (pick_cmd <= 3'd5);

  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cmd_q   <= 3'd0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cmd_q   <= cmd_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cmd_d   = cmd_q;
    rr_d    = rr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.i_acl_command_ready && (bus.i_req_a_valid || bus.i_req_b_valid)) begin
          owner_d = pick_b;
          cmd_d   = pick_cmd;
          rr_d    = ~pick_b;
          err_d   = ~pick_legal;
          state_d = pick_legal ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (!bus.i_acl_command_ready) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus.i_acl_command_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ACL_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             to_err_q;
  logic             in_txn;

  assign in_txn      = (state_q == ISSUE) || (state_q == BUSY);
  assign timeout_hit = in_txn && (cnt_q == TO_LAST);

  // Held at zero outside a transaction so every ISSUE starts from a clean count.
  always_ff @(posedge i_clk_20mhz) begin
    if (!i_rstn_20mhz) begin
      cnt_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      if (in_txn)
        cnt_q <= cnt_q + 1'b1;
      else
        cnt_q <= '0;
      if (timeout_hit)
        to_err_q <= 1'b1;
    end
  end

  assign bus.o_timeout_err = to_err_q;
`else
  assign timeout_hit       = 1'b0;
  assign bus.o_timeout_err = 1'b0;
`endif

  assign bus.o_acl_cmd_init_measur_mode  = (state_q == ISSUE) && (cmd_q == 3'd1);
  assign bus.o_acl_cmd_start_measur_mode = (state_q == ISSUE) && (cmd_q == 3'd2);
  assign bus.o_acl_cmd_init_linked_mode  = (state_q == ISSUE) && (cmd_q == 3'd3);
  assign bus.o_acl_cmd_start_linked_mode = (state_q == ISSUE) && (cmd_q == 3'd4);
  assign bus.o_acl_cmd_soft_reset        = (state_q == ISSUE) && (cmd_q == 3'd5);

  assign bus.o_req_a_done = (state_q == DONE) && !owner_q;
  assign bus.o_req_b_done = (state_q == DONE) &&  owner_q;
  assign bus.o_req_a_err  = (state_q == DONE) && !owner_q && err_q;
  assign bus.o_req_b_err  = (state_q == DONE) &&  owner_q && err_q;
  assign bus.o_grant_b    = owner_q;
  assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_acl_cmd_arbiter.sv
// Directed bench for acl_cmd_arbiter; obs packs {strobes[4:0], done_a, done_b, err_a, err_b, grant_b, busy}.
// Strobe order: init_measur, start_measur, init_linked, start_linked, soft_reset.
module tb_acl_cmd_arbiter;
  logic i_clk_20mhz = 1'b0;
  logic i_rstn_20mhz = 1'b0;
  int   errors = 0;
  int   checks = 0;

  acl_cmd_arbiter_if bus ();

  acl_cmd_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .i_clk_20mhz (i_clk_20mhz),
    .i_rstn_20mhz(i_rstn_20mhz),
    .bus         (bus.slave)
  );

  always #25 i_clk_20mhz = ~i_clk_20mhz;

  wire [4:0]  strb = {bus.o_acl_cmd_init_measur_mode, bus.o_acl_cmd_start_measur_mode,
                      bus.o_acl_cmd_init_linked_mode, bus.o_acl_cmd_start_linked_mode,
                      bus.o_acl_cmd_soft_reset};
  wire [10:0] obs  = {strb, bus.o_req_a_done, bus.o_req_b_done, bus.o_req_a_err,
                      bus.o_req_b_err, bus.o_grant_b, bus.o_busy};

  task automatic cyc();
    @(posedge i_clk_20mhz);
    #1;
  endtask

  // Driver takes the strobe, goes busy for one cycle, returns ready; ends in DONE.
  task automatic finish_txn();
    bus.i_acl_command_ready = 1'b0;
    cyc();
    bus.i_acl_command_ready = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    i_rstn_20mhz = 1'b0;
    bus.i_acl_command_ready = 1'b1;
    bus.i_req_a_valid = 1'b1; bus.i_req_a_cmd = 3'd1;
    bus.i_req_b_valid = 1'b1; bus.i_req_b_cmd = 3'd2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs !== 11'b00000_000000 || bus.o_timeout_err !== 1'b0) begin
        errors++; $display("FAIL reset_hold obs=%b to=%b expected 0", obs, bus.o_timeout_err);
      end
    end
    i_rstn_20mhz = 1'b1;
    cyc();
    checks++;
    if (obs !== 11'b10000_000001) begin
      errors++; $display("FAIL reset_release_grant obs=%b expected %b", obs, 11'b10000_000001);
    end
    bus.i_req_a_valid = 1'b0; bus.i_req_b_valid = 1'b0;
    bus.i_acl_command_ready = 1'b0;
    cyc();
    checks++;
    if (obs !== 11'b00000_000001) begin
      errors++; $display("FAIL reset_busy obs=%b expected %b", obs, 11'b00000_000001);
    end
    bus.i_acl_command_ready = 1'b1;
    cyc();
    checks++;
    if (obs !== 11'b00000_100001) begin
      errors++; $display("FAIL reset_done_a obs=%b expected %b", obs, 11'b00000_100001);
    end
    cyc();
    checks++;
    if (obs !== 11'b00000_000000) begin
      errors++; $display("FAIL reset_idle obs=%b expected %b", obs, 11'b00000_000000);
    end
  endtask

  task automatic test_basic_a();
    bus.i_req_a_valid = 1'b1; bus.i_req_a_cmd = 3'd1;
    bus.i_acl_command_ready = 1'b1;
    cyc();
    bus.i_req_a_cmd = 3'd4;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== 11'b10000_000001) begin
        errors++; $display("FAIL basic_issue[%0d] obs=%b expected %b", i, obs, 11'b10000_000001);
      end
      if (i == 0) cyc();
    end
    bus.i_acl_command_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (obs !== 11'b00000_000001) begin
        errors++; $display("FAIL basic_busy[%0d] obs=%b expected %b", i, obs, 11'b00000_000001);
      end
    end
    bus.i_acl_command_ready = 1'b1;
    cyc();
    checks++;
    if (obs !== 11'b00000_100001) begin
      errors++; $display("FAIL basic_done obs=%b expected %b", obs, 11'b00000_100001);
    end
    bus.i_req_a_valid = 1'b0;
    cyc();
    checks++;
    if (obs !== 11'b00000_000000) begin
      errors++; $display("FAIL basic_idle obs=%b expected %b", obs, 11'b00000_000000);
    end
  endtask

  task automatic test_round_robin();
    bus.i_req_a_valid = 1'b1; bus.i_req_a_cmd = 3'd2;
    bus.i_req_b_valid = 1'b1; bus.i_req_b_cmd = 3'd4;
    cyc();
    checks++;
    if (obs !== 11'b00010_000011) begin
      errors++; $display("FAIL rr_first_b obs=%b expected %b", obs, 11'b00010_000011);
    end
    finish_txn();
    checks++;
    if (obs !== 11'b00000_010011) begin
      errors++; $display("FAIL rr_done_b obs=%b expected %b", obs, 11'b00000_010011);
    end
    bus.i_req_b_valid = 1'b0;
    cyc();
    checks++;
    if (obs !== 11'b00000_000010) begin
      errors++; $display("FAIL rr_no_regrant obs=%b expected %b", obs, 11'b00000_000010);
    end
    bus.i_req_b_valid = 1'b1;
    cyc();
    checks++;
    if (obs !== 11'b01000_000001) begin
      errors++; $display("FAIL rr_second_a obs=%b expected %b", obs, 11'b01000_000001);
    end
    finish_txn();
    checks++;
    if (obs !== 11'b00000_100001) begin
      errors++; $display("FAIL rr_done_a obs=%b expected %b", obs, 11'b00000_100001);
    end
    bus.i_req_a_valid = 1'b0;
    cyc();
    bus.i_req_a_valid = 1'b1;
    cyc();
    checks++;
    if (obs !== 11'b00010_000011) begin
      errors++; $display("FAIL rr_third_b obs=%b expected %b", obs, 11'b00010_000011);
    end
    finish_txn();
    bus.i_req_a_valid = 1'b0; bus.i_req_b_valid = 1'b0;
    cyc();
    checks++;
    if (obs !== 11'b00000_000010) begin
      errors++; $display("FAIL rr_idle obs=%b expected %b", obs, 11'b00000_000010);
    end
  endtask

  task automatic test_soft_reset_priority();
    bus.i_req_a_valid = 1'b1; bus.i_req_a_cmd = 3'd3;
    bus.i_req_b_valid = 1'b1; bus.i_req_b_cmd = 3'd5;
    cyc();
    checks++;
    if (obs !== 11'b00001_000011) begin
      errors++; $display("FAIL sr_b_first obs=%b expected %b", obs, 11'b00001_000011);
    end
    finish_txn();
    bus.i_req_b_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (obs !== 11'b00100_000001) begin
      errors++; $display("FAIL sr_then_a obs=%b expected %b", obs, 11'b00100_000001);
    end
    finish_txn();
    bus.i_req_a_valid = 1'b0;
    cyc();
    bus.i_req_a_valid = 1'b1; bus.i_req_a_cmd = 3'd5;
    bus.i_req_b_valid = 1'b1; bus.i_req_b_cmd = 3'd5;
    cyc();
    checks++;
    if (obs !== 11'b00001_000011) begin
      errors++; $display("FAIL sr_both_b obs=%b expected %b", obs, 11'b00001_000011);
    end
    finish_txn();
    bus.i_req_b_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if (obs !== 11'b00001_000001) begin
      errors++; $display("FAIL sr_both_a obs=%b expected %b", obs, 11'b00001_000001);
    end
    finish_txn();
    checks++;
    if (obs !== 11'b00000_100001) begin
      errors++; $display("FAIL sr_both_done_a obs=%b expected %b", obs, 11'b00000_100001);
    end
    bus.i_req_a_valid = 1'b0;
    cyc();
  endtask

  task automatic test_illegal();
    bus.i_acl_command_ready = 1'b0;
    bus.i_req_b_valid = 1'b1; bus.i_req_b_cmd = 3'd7;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs !== 11'b00000_000000) begin
        errors++; $display("FAIL ill_blocked[%0d] obs=%b expected %b", i, obs, 11'b00000_000000);
      end
    end
    bus.i_acl_command_ready = 1'b1;
    cyc();
    checks++;
    if (obs !== 11'b00000_010111) begin
      errors++; $display("FAIL ill_b_err obs=%b expected %b", obs, 11'b00000_010111);
    end
    bus.i_req_b_valid = 1'b0;
    cyc();
    checks++;
    if (obs !== 11'b00000_000010) begin
      errors++; $display("FAIL ill_b_idle obs=%b expected %b", obs, 11'b00000_000010);
    end
    bus.i_req_a_valid = 1'b1; bus.i_req_a_cmd = 3'd0;
    cyc();
    checks++;
    if (obs !== 11'b00000_101001) begin
      errors++; $display("FAIL ill_a_err obs=%b expected %b", obs, 11'b00000_101001);
    end
    bus.i_req_a_valid = 1'b0;
    cyc();
  endtask

  task automatic test_timeout();
    int hi;
    bus.i_acl_command_ready = 1'b1;
    bus.i_req_a_valid = 1'b1; bus.i_req_a_cmd = 3'd2;
    cyc();
`ifdef ACL_ARB_TIMEOUT_EN
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (obs === 11'b01000_000001) hi++;
      cyc();
    end
    checks++;
    if (hi !== 16) begin
      errors++; $display("FAIL to_strobe_cycles got=%0d expected 16", hi);
    end
    checks++;
    if (obs !== 11'b00000_101001 || bus.o_timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_done_err obs=%b to=%b expected %b to=1", obs, bus.o_timeout_err, 11'b00000_101001);
    end
    bus.i_req_a_valid = 1'b0;
    cyc();
    checks++;
    if (obs !== 11'b00000_000000 || bus.o_timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky obs=%b to=%b expected 0 to=1", obs, bus.o_timeout_err);
    end
`else
    hi = 0;
    for (int i = 0; i < 1000; i++) begin
      if (obs === 11'b01000_000001 && bus.o_timeout_err === 1'b0) hi++;
      cyc();
    end
    checks++;
    if (hi !== 1000) begin
      errors++; $display("FAIL no_to_strobe_cycles got=%0d expected 1000", hi);
    end
    finish_txn();
    checks++;
    if (obs !== 11'b00000_100001) begin
      errors++; $display("FAIL no_to_done obs=%b expected %b", obs, 11'b00000_100001);
    end
    bus.i_req_a_valid = 1'b0;
    cyc();
`endif
  endtask

  task automatic test_reset_mid();
    bus.i_acl_command_ready = 1'b1;
    bus.i_req_a_valid = 1'b1; bus.i_req_a_cmd = 3'd1;
    cyc();
    checks++;
    if (obs !== 11'b10000_000001) begin
      errors++; $display("FAIL mid_issue obs=%b expected %b", obs, 11'b10000_000001);
    end
    i_rstn_20mhz = 1'b0;
    cyc();
    checks++;
    if (obs !== 11'b00000_000000 || bus.o_timeout_err !== 1'b0) begin
      errors++; $display("FAIL mid_reset obs=%b to=%b expected 0", obs, bus.o_timeout_err);
    end
    i_rstn_20mhz = 1'b1;
    bus.i_req_a_valid = 1'b0;
    cyc();
    checks++;
    if (obs !== 11'b00000_000000) begin
      errors++; $display("FAIL mid_after obs=%b expected 0", obs);
    end
  endtask

  initial begin
    bus.i_acl_command_ready = 1'b0;
    bus.i_req_a_valid = 1'b0; bus.i_req_b_valid = 1'b0;
    bus.i_req_a_cmd = 3'd0;   bus.i_req_b_cmd = 3'd0;
    #1;
    test_reset();
    test_basic_a();
    test_round_robin();
    test_soft_reset_priority();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
